multi_alarm: RTL and testbench

Parametrised multi-channel alarm for the digital clock. It holds `N_ALARMS` independently settable 12-hour alarm times and compares each against the running clock. On a match it drives `BEEP` through a ring/snooze state machine with snooze limit and ring auto-timeout. It sits beside the clock counter chain, taking the live time and a one-cycle minute tick, and feeds the display mux with the selected alarm's setting.

---
 rtl/multi_alarm.sv | 230 +++++++++++++++++++++++
 tb/tb_multi_alarm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm
// Brief    : N-channel 12-hour alarm bank with ring/snooze/timeout controller.
// Revision : 1.0
// ============================================================================
module multi_alarm #(
    parameter  int N_ALARMS   = 4,
    parameter  int SNOOZE_MIN = 5,
    parameter  int RING_MIN   = 2,
    parameter  int MAX_SNOOZE = 3,
    localparam int ID_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SET_MODE,
    input  logic [ID_W-1:0]     SEL,
    input  logic                SW_F1,
    input  logic                SW_F2,
    input  logic                SW_EN,
    input  logic                SW_SNOOZE,
    input  logic                SW_STOP,
    input  logic                MIN_TICK,
    input  logic                AMPM,
    input  logic [3:0]          HOUR,
    input  logic [2:0]          MINHIGH,
    input  logic [3:0]          MINLOW,
    output logic                ALM_AMPM,
    output logic [3:0]          ALM_HOUR,
    output logic [2:0]          ALM_MINHIGH,
    output logic [3:0]          ALM_MINLOW,
    output logic [N_ALARMS-1:0] ALM_EN,
    output logic                BEEP,
    output logic                SNOOZING,
    output logic [ID_W-1:0]     ACTIVE_ID
);

    localparam logic [5:0] C_RING_MIN   = 6'(RING_MIN);
    localparam logic [5:0] C_SNOOZE_MIN = 6'(SNOOZE_MIN);
    localparam logic [3:0] C_MAX_SNOOZE = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    logic [N_ALARMS-1:0] alm_ampm;
    logic [3:0]          alm_hour    [N_ALARMS];
    logic [2:0]          alm_minhigh [N_ALARMS];
    logic [3:0]          alm_minlow  [N_ALARMS];
    logic [N_ALARMS-1:0] alm_en;
    logic [N_ALARMS-1:0] sel_hit;
    logic [N_ALARMS-1:0] match;
    logic [N_ALARMS-1:0] match_prev;
    logic [N_ALARMS-1:0] trig;
    logic                any_trig;
    logic [ID_W-1:0]     first_id;

    state_t     state;
    logic [5:0] ring_tmr;
    logic [5:0] snz_tmr;
    logic [3:0] snz_cnt;

    // Decoding SEL per channel keeps out-of-range SEL values from aliasing.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            sel_hit[i] = (SEL == ID_W'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alm_ampm <= '0;
            alm_en   <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                alm_hour[i]    <= 4'd0;
                alm_minhigh[i] <= 3'd0;
                alm_minlow[i]  <= 4'd0;
            end
        end else if (SET_MODE) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (sel_hit[i]) begin
                    if (SW_F1) begin
                        if (alm_hour[i] == 4'd11) begin
                            alm_hour[i] <= 4'd0;
                            alm_ampm[i] <= ~alm_ampm[i];
                        end else begin
                            alm_hour[i] <= alm_hour[i] + 4'd1;
                        end
                    end
                    if (SW_F2) begin
                        if (alm_minlow[i] == 4'd9) begin
                            alm_minlow[i]  <= 4'd0;
                            alm_minhigh[i] <= (alm_minhigh[i] == 3'd5) ? 3'd0
                                                                       : alm_minhigh[i] + 3'd1;
                        end else begin
                            alm_minlow[i] <= alm_minlow[i] + 4'd1;
                        end
                    end
                    if (SW_EN) begin
                        alm_en[i] <= ~alm_en[i];
                    end
                end
            end
        end
    end

    always_comb begin
        ALM_AMPM    = 1'b0;
        ALM_HOUR    = 4'd0;
        ALM_MINHIGH = 3'd0;
        ALM_MINLOW  = 4'd0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (sel_hit[i]) begin
                ALM_AMPM    = alm_ampm[i];
                ALM_HOUR    = alm_hour[i];
                ALM_MINHIGH = alm_minhigh[i];
                ALM_MINLOW  = alm_minlow[i];
            end
        end
    end

    assign ALM_EN = alm_en;

    generate
        for (genvar g = 0; g < N_ALARMS; g++) begin : g_match
            assign match[g] = alm_en[g] && (alm_ampm[g] == AMPM) && (alm_hour[g] == HOUR)
                              && (alm_minhigh[g] == MINHIGH) && (alm_minlow[g] == MINLOW);
        end
    endgenerate

    // Edge detection makes each alarm fire once per matching minute; setting
    // edits never fire because the trigger is masked while SET_MODE is high.
    assign trig     = match & ~match_prev & {N_ALARMS{~SET_MODE}};
    assign any_trig = |trig;

    always_comb begin
        first_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (trig[i]) begin
                first_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            match_prev <= '0;
        end else begin
            match_prev <= match;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            BEEP      <= 1'b0;
            SNOOZING  <= 1'b0;
            ACTIVE_ID <= '0;
            ring_tmr  <= 6'd0;
            snz_tmr   <= 6'd0;
            snz_cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_trig) begin
                        state     <= S_RING;
                        BEEP      <= 1'b1;
                        SNOOZING  <= 1'b0;
                        ACTIVE_ID <= first_id;
                        ring_tmr  <= C_RING_MIN;
                        snz_cnt   <= 4'd0;
                    end
                end
                S_RING: begin
                    if (SET_MODE || SW_STOP) begin
                        state <= S_IDLE;
                        BEEP  <= 1'b0;
                    end else if (SW_SNOOZE) begin
                        if (snz_cnt < C_MAX_SNOOZE) begin
                            state    <= S_SNOOZE;
                            BEEP     <= 1'b0;
                            SNOOZING <= 1'b1;
                            snz_tmr  <= C_SNOOZE_MIN;
                            snz_cnt  <= snz_cnt + 4'd1;
                        end else begin
                            state <= S_IDLE;
                            BEEP  <= 1'b0;
                        end
                    end else if (MIN_TICK) begin
                        ring_tmr <= ring_tmr - 6'd1;
                        if (ring_tmr <= 6'd1) begin
                            state <= S_IDLE;
                            BEEP  <= 1'b0;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (SET_MODE || SW_STOP) begin
                        state    <= S_IDLE;
                        SNOOZING <= 1'b0;
                    end else if (MIN_TICK && (snz_tmr <= 6'd1)) begin
                        state    <= S_RING;
                        BEEP     <= 1'b1;
                        SNOOZING <= 1'b0;
                        snz_tmr  <= 6'd0;
                        ring_tmr <= C_RING_MIN;
                    end else if (any_trig) begin
                        state     <= S_RING;
                        BEEP      <= 1'b1;
                        SNOOZING  <= 1'b0;
                        ACTIVE_ID <= first_id;
                        ring_tmr  <= C_RING_MIN;
                        snz_cnt   <= 4'd0;
                    end else if (MIN_TICK) begin
                        snz_tmr <= snz_tmr - 6'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    BEEP     <= 1'b0;
                    SNOOZING <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_alarm
// Brief    : Scoreboard bench for multi_alarm (4 channels, default timers).
// Revision : 1.0
// ============================================================================
module tb_multi_alarm;

    localparam int N    = 4;
    localparam int ID_W = 2;

    localparam int O_BEEP = 0, O_SNZ = 1, O_ID = 2, O_HOUR = 3,
                   O_MH = 4, O_ML = 5, O_AMPM = 6, O_EN = 7;
    localparam int P_F1 = 0, P_F2 = 1, P_EN = 2, P_SNZ = 3, P_STOP = 4, P_TICK = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            SET_MODE = 1'b0;
    logic [ID_W-1:0] SEL = '0;
    logic            SW_F1 = 1'b0, SW_F2 = 1'b0, SW_EN = 1'b0;
    logic            SW_SNOOZE = 1'b0, SW_STOP = 1'b0, MIN_TICK = 1'b0;
    logic            AMPM = 1'b0;
    logic [3:0]      HOUR = 4'd0;
    logic [2:0]      MINHIGH = 3'd0;
    logic [3:0]      MINLOW = 4'd0;
    logic            ALM_AMPM;
    logic [3:0]      ALM_HOUR;
    logic [2:0]      ALM_MINHIGH;
    logic [3:0]      ALM_MINLOW;
    logic [N-1:0]    ALM_EN;
    logic            BEEP, SNOOZING;
    logic [ID_W-1:0] ACTIVE_ID;

    multi_alarm #(.N_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(2), .MAX_SNOOZE(3)) dut (
        .CLK(CLK), .RST(RST), .SET_MODE(SET_MODE), .SEL(SEL),
        .SW_F1(SW_F1), .SW_F2(SW_F2), .SW_EN(SW_EN),
        .SW_SNOOZE(SW_SNOOZE), .SW_STOP(SW_STOP), .MIN_TICK(MIN_TICK),
        .AMPM(AMPM), .HOUR(HOUR), .MINHIGH(MINHIGH), .MINLOW(MINLOW),
        .ALM_AMPM(ALM_AMPM), .ALM_HOUR(ALM_HOUR), .ALM_MINHIGH(ALM_MINHIGH),
        .ALM_MINLOW(ALM_MINLOW), .ALM_EN(ALM_EN), .BEEP(BEEP),
        .SNOOZING(SNOOZING), .ACTIVE_ID(ACTIVE_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_obs(input int which);
        case (which)
            O_BEEP:  return 32'(BEEP);
            O_SNZ:   return 32'(SNOOZING);
            O_ID:    return 32'(ACTIVE_ID);
            O_HOUR:  return 32'(ALM_HOUR);
            O_MH:    return 32'(ALM_MINHIGH);
            O_ML:    return 32'(ALM_MINLOW);
            O_AMPM:  return 32'(ALM_AMPM);
            default: return 32'(ALM_EN);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int which, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.which = which; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, get_obs(e.which), e.exp);
        end
    endtask

    // Advance one rising edge and leave time 1 unit past it for sampling/driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            case (which)
                P_F1:    SW_F1 = 1'b1;
                P_F2:    SW_F2 = 1'b1;
                P_EN:    SW_EN = 1'b1;
                P_SNZ:   SW_SNOOZE = 1'b1;
                P_STOP:  SW_STOP = 1'b1;
                default: MIN_TICK = 1'b1;
            endcase
            step();
            SW_F1 = 1'b0; SW_F2 = 1'b0; SW_EN = 1'b0;
            SW_SNOOZE = 1'b0; SW_STOP = 1'b0; MIN_TICK = 1'b0;
        end
    endtask

    task automatic set_time(input logic ap, input logic [3:0] h, input logic [2:0] mh,
                            input logic [3:0] ml);
        AMPM = ap; HOUR = h; MINHIGH = mh; MINLOW = ml;
        step();
    endtask

    task automatic expect_ring(input string tag, input logic b, input logic s, input int id);
        expect_val({tag, "_beep"}, O_BEEP, 32'(b));
        expect_val({tag, "_snz"},  O_SNZ,  32'(s));
        if (id >= 0) expect_val({tag, "_id"}, O_ID, 32'(id));
        drain();
    endtask

    initial begin
        // Reset state
        step();
        step();
        SEL = 2'd2;
        #1;
        expect_ring("rst", 1'b0, 1'b0, 0);
        expect_val("rst_en", O_EN, 32'd0);
        expect_val("rst_hour", O_HOUR, 32'd0);
        drain();
        RST = 1'b1;
        step();

        // Setting alarm 2
        SET_MODE = 1'b1;
        pulse(P_F1, 7);
        pulse(P_F2, 3);
        pulse(P_EN, 1);
        expect_val("set_hour", O_HOUR, 32'd7);
        expect_val("set_mh", O_MH, 32'd0);
        expect_val("set_ml", O_ML, 32'd3);
        expect_val("set_ampm", O_AMPM, 32'd0);
        expect_val("set_en", O_EN, 32'b0100);
        drain();
        pulse(P_F1, 5);
        expect_val("wrap_hour", O_HOUR, 32'd0);
        expect_val("wrap_ampm", O_AMPM, 32'd1);
        drain();
        pulse(P_F1, 19);
        expect_val("back_hour", O_HOUR, 32'd7);
        expect_val("back_ampm", O_AMPM, 32'd0);
        drain();

        // Minute BCD rollover on alarm 0 (stays disabled)
        SEL = 2'd0;
        pulse(P_F2, 59);
        expect_val("m59_mh", O_MH, 32'd5);
        expect_val("m59_ml", O_ML, 32'd9);
        drain();
        pulse(P_F2, 1);
        expect_val("m00_mh", O_MH, 32'd0);
        expect_val("m00_ml", O_ML, 32'd0);
        expect_val("m00_hour", O_HOUR, 32'd0);
        drain();

        // Alarms 1 and 3 at 6:00 PM
        SEL = 2'd1;
        pulse(P_F1, 18);
        pulse(P_EN, 1);
        SEL = 2'd3;
        pulse(P_F1, 18);
        pulse(P_EN, 1);
        expect_val("a3_hour", O_HOUR, 32'd6);
        expect_val("a3_ampm", O_AMPM, 32'd1);
        expect_val("en_1_2_3", O_EN, 32'b1110);
        drain();

        // Pulses ignored outside set mode
        SET_MODE = 1'b0;
        SEL = 2'd2;
        pulse(P_F1, 1);
        pulse(P_EN, 1);
        expect_val("nomode_hour", O_HOUR, 32'd7);
        expect_val("nomode_en", O_EN, 32'b1110);
        drain();

        // Alarm 2 fires at 7:03 AM
        set_time(1'b0, 4'd7, 3'd0, 4'd2);
        expect_ring("pre_703", 1'b0, 1'b0, -1);
        set_time(1'b0, 4'd7, 3'd0, 4'd3);
        expect_ring("ring_703", 1'b1, 1'b0, 2);
        pulse(P_STOP, 1);
        expect_ring("stop_703", 1'b0, 1'b0, -1);
        step(); step(); step();
        expect_ring("hold_703", 1'b0, 1'b0, -1);

        // Simultaneous matches: lowest index wins
        set_time(1'b1, 4'd6, 3'd0, 4'd0);
        expect_ring("ring_6pm", 1'b1, 1'b0, 1);

        // Three full snooze cycles, then the fourth request stops
        for (int s = 0; s < 3; s++) begin
            pulse(P_SNZ, 1);
            expect_ring($sformatf("snz%0d_enter", s), 1'b0, 1'b1, -1);
            pulse(P_TICK, 4);
            expect_ring($sformatf("snz%0d_t4", s), 1'b0, 1'b1, -1);
            pulse(P_TICK, 1);
            expect_ring($sformatf("snz%0d_t5", s), 1'b1, 1'b0, 1);
        end
        pulse(P_SNZ, 1);
        expect_ring("snz_limit", 1'b0, 1'b0, -1);

        // Ring auto-timeout
        set_time(1'b1, 4'd6, 3'd0, 4'd1);
        set_time(1'b1, 4'd6, 3'd0, 4'd0);
        expect_ring("rto_ring", 1'b1, 1'b0, 1);
        pulse(P_TICK, 1);
        expect_ring("rto_t1", 1'b1, 1'b0, -1);
        pulse(P_TICK, 1);
        expect_ring("rto_t2", 1'b0, 1'b0, -1);

        // STOP and SNOOZE together stop
        set_time(1'b1, 4'd6, 3'd0, 4'd1);
        set_time(1'b1, 4'd6, 3'd0, 4'd0);
        expect_ring("both_ring", 1'b1, 1'b0, 1);
        SW_STOP = 1'b1;
        pulse(P_SNZ, 1);
        expect_ring("both_stop", 1'b0, 1'b0, -1);

        // A new trigger during snooze re-rings with the new index
        set_time(1'b1, 4'd6, 3'd0, 4'd1);
        set_time(1'b1, 4'd6, 3'd0, 4'd0);
        pulse(P_SNZ, 1);
        expect_ring("retrig_snz", 1'b0, 1'b1, 1);
        set_time(1'b0, 4'd7, 3'd0, 4'd3);
        expect_ring("retrig_ring", 1'b1, 1'b0, 2);

        // Set mode cancels ringing; leaving it on a matching time does not fire
        SET_MODE = 1'b1;
        step();
        expect_ring("cancel", 1'b0, 1'b0, -1);
        SET_MODE = 1'b0;
        step(); step();
        expect_ring("no_fire_exit", 1'b0, 1'b0, -1);

        // Asynchronous reset mid-ring
        set_time(1'b0, 4'd7, 3'd0, 4'd2);
        set_time(1'b0, 4'd7, 3'd0, 4'd3);
        expect_ring("pre_rst_ring", 1'b1, 1'b0, 2);
        #1;
        RST = 1'b0;
        #1;
        expect_ring("async_rst", 1'b0, 1'b0, 0);
        expect_val("async_en", O_EN, 32'd0);
        expect_val("async_hour", O_HOUR, 32'd0);
        expect_val("async_ml", O_ML, 32'd0);
        expect_val("async_ampm", O_AMPM, 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
